mem_bus_arbiter: RTL and testbench

- Shares one single-ported memory bus between the core's instruction-fetch port and data port.
- Arbitrates pending requests round-robin and holds each grant until the memory acknowledges.
- Drives the core-wide `stall` that freezes the control-unit sequencer while a bus access is outstanding.
- Sits between the fetch/load-store logic and the memory or peripheral interconnect.

---
 rtl/mem_bus_arbiter.sv | 150 +++++++++++++++
 tb/tb_mem_bus_arbiter.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: round-robin arbiter sharing one single-ported memory bus
// between the instruction-fetch port and the data port. Drives the core stall.
// Optional grant watchdog enabled by defining MEM_BUS_ARBITER_TIMEOUT_EN.
module mem_bus_arbiter #(
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                i_req,
  input  logic [ADDR_W-1:0]   i_addr,
  output logic [DATA_W-1:0]   i_rdata,
  output logic                i_ack,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  input  logic [DATA_W/8-1:0] d_be,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                d_ack,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic [DATA_W-1:0]   mem_rdata,
  input  logic                mem_ack,
  output logic                stall,
  output logic                bus_error
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam logic PORT_I = 1'b0;
  localparam logic PORT_D = 1'b1;

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;

  state_t state, state_d;
  logic   last, last_d;
  logic   timeout_c;
  logic   done_c;

  // Reject watchdog limits the 8-bit counter cannot represent.
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("mem_bus_arbiter: TIMEOUT_CYCLES must be within 1..255");
  end

  // A grant completes on memory ack or on watchdog expiry.
  assign done_c = mem_ack | timeout_c;

`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] to_cnt;

  // Count granted cycles without ack; cleared whenever a new grant begins.
  always_ff @(posedge clk) begin
    if (rst) begin
      to_cnt <= '0;
    end else if (state == IDLE || done_c) begin
      to_cnt <= '0;
    end else begin
      to_cnt <= to_cnt + 8'd1;
    end
  end

  // Expiry when this cycle would be the TIMEOUT_CYCLES-th unacked grant cycle.
  assign timeout_c = (state != IDLE) && (to_cnt == TO_LAST) && !mem_ack;
`else
  // Without the watchdog a grant waits for mem_ack indefinitely.
  assign timeout_c = 1'b0;
`endif

  // State and round-robin history register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      last  <= PORT_D;
    end else begin
      state <= state_d;
      last  <= last_d;
    end
  end

  // Arbitration, bus mux and completion decode.
  always_comb begin
    state_d   = state;
    last_d    = last;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    i_ack     = 1'b0;
    d_ack     = 1'b0;
    i_rdata   = '0;
    d_rdata   = '0;
    bus_error = 1'b0;
    unique case (state)
      IDLE: begin
        if (i_req && (!d_req || last == PORT_D)) begin
          state_d = GRANT_I;
        end else if (d_req) begin
          state_d = GRANT_D;
        end
      end
      GRANT_I: begin
        mem_req  = 1'b1;
        mem_addr = i_addr;
        mem_be   = {BE_W{1'b1}};
        if (done_c) begin
          i_ack     = 1'b1;
          i_rdata   = mem_ack ? mem_rdata : '0;
          bus_error = timeout_c;
          last_d    = PORT_I;
          state_d   = d_req ? GRANT_D : IDLE;
        end
      end
      GRANT_D: begin
        mem_req   = 1'b1;
        mem_we    = d_we;
        mem_addr  = d_addr;
        mem_wdata = d_wdata;
        mem_be    = d_be;
        if (done_c) begin
          d_ack     = 1'b1;
          d_rdata   = mem_ack ? mem_rdata : '0;
          bus_error = timeout_c;
          last_d    = PORT_D;
          state_d   = i_req ? GRANT_I : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Freeze the sequencer while any request is still outstanding.
  assign stall = (i_req & ~i_ack) | (d_req & ~d_ack);

  // Requesters must hold their request until acknowledged.
  a_i_req_held: assert property (@(posedge clk) disable iff (rst)
    (state == GRANT_I && !i_ack) |=> i_req)
    else $error("mem_bus_arbiter: i_req dropped before i_ack");

  // Same rule for the data port.
  a_d_req_held: assert property (@(posedge clk) disable iff (rst)
    (state == GRANT_D && !d_ack) |=> d_req)
    else $error("mem_bus_arbiter: d_req dropped before d_ack");

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed scoreboard bench for mem_bus_arbiter.
module tb_mem_bus_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned BE_W   = DATA_W / 8;
  localparam int unsigned TO     = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_req, d_req, d_we, mem_ack;
  logic [ADDR_W-1:0] i_addr, d_addr;
  logic [DATA_W-1:0] d_wdata, mem_rdata;
  logic [BE_W-1:0]   d_be;
  logic [DATA_W-1:0] i_rdata, d_rdata, mem_wdata;
  logic              i_ack, d_ack, mem_req, mem_we, stall, bus_error;
  logic [ADDR_W-1:0] mem_addr;
  logic [BE_W-1:0]   mem_be;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .i_ack(i_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .d_ack(d_ack),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .bus_error(bus_error)
  );

  typedef struct {
    logic        port;   // 0 = fetch, 1 = data
    logic [31:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic [31:0] rdata;
    logic        err;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive point: just after the rising edge.
  task automatic next();
    @(posedge clk);
    #1;
  endtask

  // Sample point: falling edge, after combinational settle.
  task automatic smp();
    @(negedge clk);
  endtask

  task automatic push_i(input logic [31:0] a, input logic [31:0] rd, input logic err);
    exp_t e;
    e.port = 1'b0; e.addr = a; e.we = 1'b0; e.wdata = '0; e.be = 4'hF; e.rdata = rd; e.err = err;
    sb.push_back(e);
  endtask

  task automatic push_d(input logic [31:0] a, input logic we, input logic [31:0] wd,
                        input logic [3:0] be, input logic [31:0] rd);
    exp_t e;
    e.port = 1'b1; e.addr = a; e.we = we; e.wdata = wd; e.be = be; e.rdata = rd; e.err = 1'b0;
    sb.push_back(e);
  endtask

  // Compare the completing access against the oldest expected transaction.
  task automatic check_ack(input string tag);
    exp_t e;
    chk({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      chk({tag, "_mem_req"},   64'(mem_req),   64'(1));
      chk({tag, "_i_ack"},     64'(i_ack),     64'(!e.port));
      chk({tag, "_d_ack"},     64'(d_ack),     64'(e.port));
      chk({tag, "_mem_addr"},  64'(mem_addr),  64'(e.addr));
      chk({tag, "_mem_we"},    64'(mem_we),    64'(e.we));
      chk({tag, "_mem_be"},    64'(mem_be),    64'(e.be));
      if (e.we) chk({tag, "_mem_wdata"}, 64'(mem_wdata), 64'(e.wdata));
      chk({tag, "_rdata"},     64'(e.port ? d_rdata : i_rdata), 64'(e.rdata));
      chk({tag, "_bus_error"}, 64'(bus_error), 64'(e.err));
      chk({tag, "_stall"},     64'(stall),     64'(e.port ? i_req : d_req));
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    next();
    next();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state.
    rst = 1'b1;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0; mem_rdata = '0;
    next();
    next();
    smp();
    chk("rst_mem_req",   64'(mem_req),   64'(0));
    chk("rst_mem_we",    64'(mem_we),    64'(0));
    chk("rst_mem_addr",  64'(mem_addr),  64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_mem_be",    64'(mem_be),    64'(0));
    chk("rst_acks",      64'({i_ack, d_ack}), 64'(0));
    chk("rst_rdata",     64'({i_rdata, d_rdata}), 64'(0));
    chk("rst_bus_error", 64'(bus_error), 64'(0));
    chk("rst_stall",     64'(stall),     64'(0));
    next();
    rst = 1'b0;

    // Single fetch acked in its first granted cycle.
    i_req = 1'b1; i_addr = 32'h100;
    push_i(32'h100, 32'h0050_0093, 1'b0);
    smp();
    chk("t1_c0_stall",   64'(stall),   64'(1));
    chk("t1_c0_mem_req", 64'(mem_req), 64'(0));
    next();
    mem_ack = 1'b1; mem_rdata = 32'h0050_0093;
    smp();
    check_ack("t1_c1");
    next();
    i_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    smp();
    chk("t1_c2_stall",   64'(stall),   64'(0));
    chk("t1_c2_mem_req", 64'(mem_req), 64'(0));

    // Simultaneous fetch and store after reset: fetch first, store with no bubble.
    do_reset();
    i_req = 1'b1; i_addr = 32'h104;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h2000; d_wdata = 32'hDEAD_BEEF; d_be = 4'hF;
    push_i(32'h104, 32'h1111_2222, 1'b0);
    push_d(32'h2000, 1'b1, 32'hDEAD_BEEF, 4'hF, 32'h0);
    smp();
    chk("t2_c0_stall",   64'(stall),   64'(1));
    chk("t2_c0_mem_req", 64'(mem_req), 64'(0));
    next();
    mem_ack = 1'b1; mem_rdata = 32'h1111_2222;
    smp();
    check_ack("t2_i");
    next();
    i_req = 1'b0; mem_rdata = '0;
    smp();
    check_ack("t2_d");
    next();
    d_req = 1'b0; d_we = 1'b0; mem_ack = 1'b0;
    smp();
    chk("t2_idle_mem_req", 64'(mem_req), 64'(0));

    // Continuous contention: six alternating accesses, fetch first.
    for (int k = 0; k < 3; k++) begin
      push_i(32'h200 + 32'(4 * k), 32'h1000 + 32'(k), 1'b0);
      push_d(32'h3000 + 32'(4 * k), 1'b0, 32'h0, 4'h3, 32'h2000 + 32'(k));
    end
    i_req = 1'b1; i_addr = 32'h200;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h3000; d_be = 4'h3;
    smp();
    for (int j = 0; j < 6; j++) begin
      next();
      if (j > 0) begin
        if (((j - 1) % 2) == 0) begin
          if (j - 1 < 4) i_addr = i_addr + 32'd4;
          else           i_req  = 1'b0;
        end else begin
          d_addr = d_addr + 32'd4;
        end
      end
      mem_ack   = 1'b1;
      mem_rdata = ((j % 2) == 0) ? 32'h1000 + 32'(j / 2) : 32'h2000 + 32'(j / 2);
      smp();
      check_ack($sformatf("t3_acc%0d", j));
    end
    next();
    d_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    smp();
    chk("t3_idle_mem_req", 64'(mem_req), 64'(0));

    // Load from 0x40 with mem_ack delayed by three cycles.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40; d_be = 4'hF;
    push_d(32'h40, 1'b0, 32'h0, 4'hF, 32'hCAFE_F00D);
    smp();
    chk("t4_c0_stall", 64'(stall), 64'(1));
    for (int w = 0; w < 3; w++) begin
      next();
      mem_ack = 1'b0; mem_rdata = 32'h1234_5678;
      smp();
      chk($sformatf("t4_w%0d_mem_req", w),  64'(mem_req),  64'(1));
      chk($sformatf("t4_w%0d_mem_addr", w), 64'(mem_addr), 64'(32'h40));
      chk($sformatf("t4_w%0d_d_ack", w),    64'(d_ack),    64'(0));
      chk($sformatf("t4_w%0d_d_rdata", w),  64'(d_rdata),  64'(0));
      chk($sformatf("t4_w%0d_stall", w),    64'(stall),    64'(1));
    end
    next();
    mem_ack = 1'b1; mem_rdata = 32'hCAFE_F00D;
    smp();
    check_ack("t4_ack");
    next();
    d_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    smp();
    chk("t4_after_d_ack",   64'(d_ack),   64'(0));
    chk("t4_after_mem_req", 64'(mem_req), 64'(0));

    // Reset while the data grant waits on memory; fetch wins afterwards.
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h80; d_be = 4'hF;
    next();
    i_req = 1'b1; i_addr = 32'h300;
    smp();
    chk("t5_wait_mem_req",  64'(mem_req),  64'(1));
    chk("t5_wait_mem_addr", 64'(mem_addr), 64'(32'h80));
    next();
    rst = 1'b1;
    smp();
    chk("t5_rst_d_ack", 64'(d_ack), 64'(0));
    next();
    rst = 1'b0;
    smp();
    chk("t5_post_mem_req",   64'(mem_req),   64'(0));
    chk("t5_post_d_ack",     64'(d_ack),     64'(0));
    chk("t5_post_bus_error", 64'(bus_error), 64'(0));
    chk("t5_post_stall",     64'(stall),     64'(1));
    push_i(32'h300, 32'hA5A5_0001, 1'b0);
    push_d(32'h80, 1'b0, 32'h0, 4'hF, 32'hA5A5_0002);
    next();
    mem_ack = 1'b1; mem_rdata = 32'hA5A5_0001;
    smp();
    check_ack("t5_i");
    next();
    i_req = 1'b0; mem_rdata = 32'hA5A5_0002;
    smp();
    check_ack("t5_d");
    next();
    d_req = 1'b0; mem_ack = 1'b0; mem_rdata = '0;
    smp();
    chk("t5_idle_mem_req", 64'(mem_req), 64'(0));

    // Memory never acks a fetch.
    i_req = 1'b1; i_addr = 32'h500; mem_rdata = 32'hFFFF_FFFF;
`ifdef MEM_BUS_ARBITER_TIMEOUT_EN
    push_i(32'h500, 32'h0, 1'b1);
    smp();
    for (int c = 1; c < int'(TO); c++) begin
      next();
      smp();
      chk($sformatf("t6_c%0d_i_ack", c),     64'(i_ack),     64'(0));
      chk($sformatf("t6_c%0d_bus_error", c), 64'(bus_error), 64'(0));
      chk($sformatf("t6_c%0d_mem_req", c),   64'(mem_req),   64'(1));
    end
    next();
    smp();
    check_ack("t6_timeout");
    next();
    i_req = 1'b0;
    smp();
    chk("t6_idle_mem_req",   64'(mem_req),   64'(0));
    chk("t6_idle_bus_error", 64'(bus_error), 64'(0));
`else
    smp();
    for (int c = 0; c < 100; c++) next();
    smp();
    chk("t6_hold_mem_req",   64'(mem_req),   64'(1));
    chk("t6_hold_i_ack",     64'(i_ack),     64'(0));
    chk("t6_hold_bus_error", 64'(bus_error), 64'(0));
    next();
    rst = 1'b1;
    next();
    i_req = 1'b0;
    next();
    rst = 1'b0;
    smp();
    chk("t6_rst_mem_req", 64'(mem_req), 64'(0));
`endif

    chk("sb_drained", 64'(sb.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
